// File: rtl/intpol_pkg.sv
// Shared constants and helpers for the interpolator controller slice.
package intpol_pkg;

  localparam int   DEF_NUM_M     = 3;
  localparam int   DEF_INTP_LOG2 = 2;
  localparam logic MODE_PASS     = 1'b0;
  localparam logic MODE_INTP     = 1'b1;

  function automatic int calc_m_w(input int num_m);
    return $clog2(num_m + 1);
  endfunction

endpackage

// File: rtl/intpol_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module intpol_sat_cnt #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/intpol_nxt_ste_lgc_p.sv
// Next-state/counter logic for the interpolator controller: sample count,
// M-register load sequencing, tap select, interpolation phase and FIFO bypass.
module intpol_nxt_ste_lgc_p
  import intpol_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_M      = DEF_NUM_M,
  parameter int INTP_LOG2  = DEF_INTP_LOG2,
  parameter int M_W        = calc_m_w(NUM_M)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  en_sum,
  input  logic                  en_M_addr,
  input  logic                  done,
  input  logic                  busy,
  input  logic                  Empty,
  input  logic                  Afull,
  input  logic [DATA_WIDTH:0]   ilen,
  output logic                  comp_cnt,
  output logic                  comp_addr,
  output logic [NUM_M-1:0]      Ld_M,
  output logic [M_W-1:0]        sel_xi,
  output logic [INTP_LOG2-1:0]  phase,
  output logic                  sample_tick,
  output logic                  FIFO_bypass
);

  localparam int CW = DATA_WIDTH + 1;

  logic [CW-1:0]        w_cnt;
  logic [CW:0]          w_cnt_inc;
  logic [CW-1:0]        w_ilen_m1;
  logic [M_W-1:0]       w_m_cnt;
  logic                 w_tick;
  logic [INTP_LOG2-1:0] r_phase;
  logic                 r_fifo_bypass;

  // done restarts the frame count even if en_sum is asserted
  intpol_sat_cnt #(.W(CW), .MAX({CW{1'b1}})) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (clear | done),
    .i_en  (en_sum),
    .o_cnt (w_cnt)
  );

  // dropping en_M_addr aborts the load sequence
  intpol_sat_cnt #(.W(M_W), .MAX(M_W'(NUM_M))) u_m_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (clear | ~en_M_addr),
    .i_en  (en_M_addr),
    .o_cnt (w_m_cnt)
  );

  for (genvar i = 0; i < NUM_M; i++) begin : g_ld
    assign Ld_M[i] = (w_m_cnt == M_W'(i + 1));
  end

  assign comp_addr = (w_m_cnt == M_W'(NUM_M));

  assign w_ilen_m1 = ilen - 1'b1;
  assign comp_cnt  = (ilen == '0) | (w_cnt >= w_ilen_m1);

  // extra bit keeps cnt+1 from wrapping when cnt is saturated
  assign w_cnt_inc = {1'b0, w_cnt} + 1'b1;
  assign sel_xi    = (w_cnt_inc >= (CW + 1)'(NUM_M)) ? M_W'(NUM_M) : w_cnt_inc[M_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_phase <= '0;
    else if (clear || done || (mode != MODE_INTP))
      r_phase <= '0;
    else if (en_sum)
      r_phase <= r_phase + 1'b1;
  end

  assign phase       = r_phase;
  assign w_tick      = (mode == MODE_INTP) ? (en_sum & (&r_phase)) : en_sum;
  assign sample_tick = w_tick & ~done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_fifo_bypass <= 1'b0;
    else if (clear)
      r_fifo_bypass <= 1'b0;
    else
      r_fifo_bypass <= busy & ~Empty & ~Afull;
  end

  assign FIFO_bypass = r_fifo_bypass;

endmodule

// File: tb/tb_intpol_nxt_ste_lgc_p.sv
// Bench for intpol_nxt_ste_lgc_p: directed scenarios plus random traffic
// against an integer-level reference model.
module tb_intpol_nxt_ste_lgc_p;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_M      = 3;
  localparam int INTP_LOG2  = 2;
  localparam int M_W        = 2;
  localparam int NPH        = 1 << INTP_LOG2;
  localparam longint unsigned CNT_MAX = (64'd1 << (DATA_WIDTH + 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rstn, clear, mode, en_sum, en_M_addr, done, busy, Empty, Afull;
  logic [DATA_WIDTH:0]  ilen;
  logic                 comp_cnt, comp_addr, sample_tick, FIFO_bypass;
  logic [NUM_M-1:0]     Ld_M;
  logic [M_W-1:0]       sel_xi;
  logic [INTP_LOG2-1:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int              m_m;
  longint unsigned m_cnt;
  int              m_ph;
  bit              m_byp;

  intpol_nxt_ste_lgc_p #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_M(NUM_M), .INTP_LOG2(INTP_LOG2)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .mode(mode), .en_sum(en_sum),
    .en_M_addr(en_M_addr), .done(done), .busy(busy), .Empty(Empty), .Afull(Afull),
    .ilen(ilen), .comp_cnt(comp_cnt), .comp_addr(comp_addr), .Ld_M(Ld_M),
    .sel_xi(sel_xi), .phase(phase), .sample_tick(sample_tick), .FIFO_bypass(FIFO_bypass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_m = 0; m_cnt = 0; m_ph = 0; m_byp = 0;
  endtask

  task automatic check_all();
    longint unsigned il;
    longint unsigned sel;
    bit ecc, etick;
    il    = 64'(ilen);
    ecc   = (il == 0) ? 1'b1 : (m_cnt >= il - 1);
    sel   = (m_cnt + 1 < NUM_M) ? m_cnt + 1 : NUM_M;
    etick = done ? 1'b0 : (mode ? (en_sum && m_ph == NPH - 1) : en_sum);
    chk("comp_cnt",    64'(comp_cnt),    64'(ecc));
    chk("comp_addr",   64'(comp_addr),   64'(m_m == NUM_M));
    chk("Ld_M",        64'(Ld_M),        (m_m == 0) ? 64'd0 : (64'd1 << (m_m - 1)));
    chk("sel_xi",      64'(sel_xi),      sel);
    chk("phase",       64'(phase),       64'(m_ph));
    chk("sample_tick", 64'(sample_tick), 64'(etick));
    chk("FIFO_bypass", 64'(FIFO_bypass), 64'(m_byp));
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    if (clear) model_reset();
    else begin
      m_m   = en_M_addr ? ((m_m + 1 > NUM_M) ? NUM_M : m_m + 1) : 0;
      if (done)        m_cnt = 0;
      else if (en_sum) m_cnt = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
      if (done || !mode) m_ph = 0;
      else if (en_sum)   m_ph = (m_ph + 1) % NPH;
      m_byp = busy && !Empty && !Afull;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 0; mode = 0; en_sum = 0; en_M_addr = 0; done = 0;
    busy = 0; Empty = 1; Afull = 0;
  endtask

  int ld_exp [5] = '{1, 2, 4, 4, 4};
  int sel_exp[5] = '{1, 2, 3, 3, 3};
  int ph_exp [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    idle_inputs();
    rstn = 0; ilen = 33'd5;
    model_reset();
    @(negedge clk);
    #1 check_all();
    ilen = 33'd1;
    #1 chk("rst_comp_cnt_ilen1", 64'(comp_cnt), 64'd1);
    chk("rst_sel_xi", 64'(sel_xi), 64'd1);
    @(negedge clk);
    rstn = 1; ilen = 33'd5;

    // M-load sequence
    en_M_addr = 1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("ld_seq", 64'(Ld_M), 64'(ld_exp[k]));
      chk("ld_comp_addr", 64'(comp_addr), 64'(k >= 2));
    end
    en_M_addr = 0;
    cycle();
    chk("ld_abort", 64'(Ld_M), 64'd0);

    // Frame length, ilen=5
    en_sum = 1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("sel_seq", 64'(sel_xi), 64'(sel_exp[k]));
      chk("cc_seq", 64'(comp_cnt), 64'(k >= 4));
      cycle();
    end
    en_sum = 0; done = 1;
    cycle();
    done = 0;
    #1 chk("done_cc", 64'(comp_cnt), 64'd0);
    ilen = 33'd0; en_sum = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("ilen0_cc", 64'(comp_cnt), 64'd1);
    end
    en_sum = 0; done = 1; cycle(); done = 0;

    // Interpolation phase, mode=1 then mode=0
    ilen = 33'd20; mode = 1; en_sum = 1;
    for (int k = 0; k < 9; k++) begin
      #1 chk("intp_tick", 64'(sample_tick), 64'(k == 3 || k == 7));
      cycle();
      chk("intp_phase", 64'(phase), 64'(ph_exp[k]));
    end
    mode = 0;
    for (int k = 0; k < 9; k++) begin
      #1 chk("pass_tick", 64'(sample_tick), 64'd1);
      cycle();
      chk("pass_phase", 64'(phase), 64'd0);
    end
    en_sum = 0;

    // FIFO bypass
    busy = 1; Empty = 1; cycle();
    Empty = 0;
    #1 chk("byp_before", 64'(FIFO_bypass), 64'd0);
    cycle();
    chk("byp_rise", 64'(FIFO_bypass), 64'd1);
    cycle(); cycle();
    Afull = 1;
    #1 chk("byp_hold", 64'(FIFO_bypass), 64'd1);
    cycle();
    chk("byp_fall", 64'(FIFO_bypass), 64'd0);
    idle_inputs();

    // Priority: done with en_sum at cnt=7
    done = 1; cycle(); done = 0;
    mode = 1; en_sum = 1;
    repeat (7) cycle();
    done = 1;
    #1 chk("prio_tick", 64'(sample_tick), 64'd0);
    cycle();
    done = 0; en_sum = 0;
    #1 chk("prio_phase", 64'(phase), 64'd0);
    chk("prio_sel", 64'(sel_xi), 64'd1);

    // clear mid-M-sequence
    en_M_addr = 1; busy = 1; Empty = 0; cycle(); cycle();
    clear = 1; cycle(); clear = 0;
    en_M_addr = 0; busy = 0; Empty = 1;
    #1 chk("clr_ld", 64'(Ld_M), 64'd0);
    chk("clr_byp", 64'(FIFO_bypass), 64'd0);

    // asynchronous reset between edges
    en_M_addr = 1; en_sum = 1; busy = 1; Empty = 0; mode = 1;
    repeat (3) cycle();
    @(posedge clk); #2;
    en_sum = 0; rstn = 0;
    model_reset();
    #1 chk("arst_ld", 64'(Ld_M), 64'd0);
    chk("arst_phase", 64'(phase), 64'd0);
    chk("arst_byp", 64'(FIFO_bypass), 64'd0);
    chk("arst_sel", 64'(sel_xi), 64'd1);
    @(negedge clk);
    rstn = 1; idle_inputs();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      clear     = ($urandom_range(0, 49) == 0);
      done      = ($urandom_range(0, 19) == 0);
      mode      = ($urandom_range(0, 9) != 0);
      en_sum    = $urandom_range(0, 3) != 0;
      en_M_addr = $urandom_range(0, 5) != 0;
      busy      = $urandom_range(0, 1);
      Empty     = $urandom_range(0, 3) == 0;
      Afull     = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 15) == 0) ilen = 33'($urandom_range(0, 12));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
